// File: rtl/uart_mmio.sv
// Memory-mapped UART register block with TX/RX FIFOs for the picorv32 native bus.
// Optional interrupt logic and IRQEN register built when UART_MMIO_IRQ_EN is defined.
module uart_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx_write,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_finished,
    input  logic        uart_rx_ready,
    input  logic [7:0]  uart_rx_data
`ifdef UART_MMIO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t      r_state;
    logic [7:0]  r_tx_mem [TX_DEPTH];
    logic [7:0]  r_rx_mem [RX_DEPTH];
    logic [TAW:0] r_tx_wp;
    logic [TAW:0] r_tx_rp;
    logic [RAW:0] r_rx_wp;
    logic [RAW:0] r_rx_rp;
    logic        r_overrun;

    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_req;
    logic        w_stall;
    logic        w_acc;
    logic        w_tx_empty;
    logic        w_tx_full;
    logic        w_rx_empty;
    logic        w_rx_full;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_ovr_set;
    logic        w_ovr_clr;
    logic        w_tx_busy;
    logic [7:0]  w_rx_head;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_hit = mem_addr[31:4] == BASE_ADDR[31:4];
    assign w_off = mem_addr[3:2];
    assign w_wr  = |mem_wstrb;
    assign w_req = mem_valid & w_hit & !mem_ready;

    assign w_tx_empty = r_tx_wp == r_tx_rp;
    assign w_tx_full  = (r_tx_wp[TAW] != r_tx_rp[TAW]) &&
                        (r_tx_wp[TAW-1:0] == r_tx_rp[TAW-1:0]);
    assign w_rx_empty = r_rx_wp == r_rx_rp;
    assign w_rx_full  = (r_rx_wp[RAW] != r_rx_rp[RAW]) &&
                        (r_rx_wp[RAW-1:0] == r_rx_rp[RAW-1:0]);

    // A DATA write into a full TX FIFO is held off rather than dropped
    assign w_stall = w_req & (w_off == 2'd0) & mem_wstrb[0] & w_tx_full;
    assign w_acc   = w_req & !w_stall;

    assign w_tx_push = w_acc & (w_off == 2'd0) & mem_wstrb[0];
    assign w_tx_pop  = (r_state == S_IDLE) & !w_tx_empty;
    assign w_rx_pop  = w_acc & (w_off == 2'd0) & !w_wr & !w_rx_empty;
    assign w_rx_push = uart_rx_ready & (!w_rx_full | w_rx_pop);
    assign w_ovr_set = uart_rx_ready & w_rx_full & !w_rx_pop;
    assign w_ovr_clr = w_acc & (w_off == 2'd1) & mem_wstrb[0] & mem_wdata[2];
    assign w_tx_busy = (r_state != S_IDLE) | !w_tx_empty;
    assign w_rx_head = r_rx_mem[r_rx_rp[RAW-1:0]];

    assign w_unused = &{1'b0, mem_addr[1:0], mem_wdata[31:8]};

`ifdef UART_MMIO_IRQ_EN
    logic r_rx_irq_en;
    logic r_tx_irq_en;
    logic w_irqen_wr;

    assign w_irqen_wr = w_acc & (w_off == 2'd2) & mem_wstrb[0];

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_rx_irq_en <= 1'b0;
            r_tx_irq_en <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (w_irqen_wr) begin
                r_rx_irq_en <= mem_wdata[0];
                r_tx_irq_en <= mem_wdata[1];
            end
            irq <= (r_rx_irq_en & !w_rx_empty) |
                   (r_tx_irq_en & w_tx_empty & (r_state == S_IDLE));
        end
    end
`endif

    always_comb begin
        w_rdata = 32'h0;
        if (!w_wr) begin
            case (w_off)
                2'd0: w_rdata = {23'b0, w_rx_empty,
                                 w_rx_empty ? 8'h00 : w_rx_head};
                2'd1: w_rdata = {28'b0, w_tx_busy, r_overrun,
                                 w_tx_full, !w_rx_empty};
`ifdef UART_MMIO_IRQ_EN
                2'd2: w_rdata = {30'b0, r_tx_irq_en, r_rx_irq_en};
`endif
                default: w_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= mem_wdata[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wp[RAW-1:0]] <= uart_rx_data;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            r_tx_wp   <= '0;
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_overrun <= 1'b0;
        end else begin
            mem_ready <= w_acc;
            mem_rdata <= w_acc ? w_rdata : 32'h0;
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            if (w_ovr_set)      r_overrun <= 1'b1;
            else if (w_ovr_clr) r_overrun <= 1'b0;
        end
    end

    // Transmit sequencer: byte is held on uart_tx_data until the frame is done
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state       <= S_IDLE;
            r_tx_rp       <= '0;
            uart_tx_write <= 1'b0;
            uart_tx_data  <= 8'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    uart_tx_write <= 1'b0;
                    if (w_tx_pop) begin
                        uart_tx_data  <= r_tx_mem[r_tx_rp[TAW-1:0]];
                        uart_tx_write <= 1'b1;
                        r_tx_rp       <= r_tx_rp + 1'b1;
                        r_state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    uart_tx_write <= 1'b0;
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    uart_tx_write <= 1'b0;
                    if (uart_tx_finished) r_state <= S_IDLE;
                end
                default: begin
                    uart_tx_write <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio with a simple UART frame model.
// Build with UART_MMIO_IRQ_EN defined to also exercise the interrupt path.
module tb_uart_mmio;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int MAXC = 64;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx_write;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_finished = 1'b0;
    logic        uart_rx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
`ifdef UART_MMIO_IRQ_EN
    logic        irq;
`endif

    uart_mmio dut (
        .clk              (clk),
        .n_reset          (n_reset),
        .mem_valid        (mem_valid),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wstrb        (mem_wstrb),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .uart_tx_write    (uart_tx_write),
        .uart_tx_data     (uart_tx_data),
        .uart_tx_finished (uart_tx_finished),
        .uart_rx_ready    (uart_rx_ready),
        .uart_rx_data     (uart_rx_data)
`ifdef UART_MMIO_IRQ_EN
        ,
        .irq              (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // UART transmitter model: records bytes, ends each frame after 4 cycles
    logic [7:0] tx_q[$];
    int  frame_left = 0;
    logic uart_hold = 1'b0;
    logic unstable = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            uart_tx_finished = 1'b0;
            if (uart_tx_write) begin
                tx_q.push_back(uart_tx_data);
                frame_left = 4;
            end else if (frame_left > 0) begin
                if (uart_tx_data !== tx_q[tx_q.size()-1]) unstable = 1'b1;
                if (!uart_hold) begin
                    frame_left--;
                    if (frame_left == 0) uart_tx_finished = 1'b1;
                end
            end
        end
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd,
                       output int lat);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= MAXC; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                lat = i;
                rd  = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] off,
                          input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus(BASE + {28'h0, off}, 32'h0, 4'h0, rd, lat);
        check({tag, "_lat"}, lat, 1);
        check(tag, rd, exp);
    endtask

    task automatic wr(input string tag, input logic [3:0] off,
                      input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        int lat;
        bus(BASE + {28'h0, off}, d, s, rd, lat);
        check({tag, "_lat"}, lat, 1);
    endtask

    task automatic rx_inject(input logic [7:0] b);
        @(negedge clk);
        uart_rx_ready = 1'b1;
        uart_rx_data  = b;
        @(negedge clk);
        uart_rx_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        int base_i;
        int nready;

        repeat (3) @(negedge clk);
        check("rst_ready", mem_ready, 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_txw", uart_tx_write, 0);
        check("rst_txd", uart_tx_data, 0);
        n_reset = 1'b1;

        rd_chk("t1_status", 4'h4, 32'h0);

        // Held request must be acked every other cycle, never twice in a row
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h4;
        mem_wstrb = 4'h0;
        nready = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ready) nready++;
        end
        mem_valid = 1'b0;
        check("held_valid_acks", nready, 2);

        wr("t2_w41", 4'h0, 32'h41, 4'h1);
        wr("t2_w42", 4'h0, 32'h42, 4'h1);
        rd_chk("t2_busy", 4'h4, 32'h8);
        repeat (30) @(negedge clk);
        rd_chk("t2_idle", 4'h4, 32'h0);
        check("t2_count", tx_q.size(), 2);
        check("t2_b0", tx_q[0], 8'h41);
        check("t2_b1", tx_q[1], 8'h42);

        wr("nostrb_w", 4'h0, 32'h99, 4'h2);
        repeat (20) @(negedge clk);
        check("nostrb_count", tx_q.size(), 2);

        base_i = tx_q.size();
        uart_hold = 1'b1;
        for (int i = 0; i < 17; i++) wr("t3_fill", 4'h0, 32'h60 + i, 4'h1);
        rd_chk("t3_full", 4'h4, 32'hA);
        fork
            bus(BASE, 32'h71, 4'h1, rd, lat);
            begin
                repeat (10) @(negedge clk);
                uart_hold = 1'b0;
            end
        join
        check("t3_stalled", lat > 10, 1);
        check("t3_acked", lat != -1, 1);
        repeat (300) @(negedge clk);
        check("t3_count", tx_q.size() - base_i, 18);
        for (int i = 0; i < 18; i++)
            check("t3_order", tx_q[base_i + i], 8'h60 + i);
        rd_chk("t3_idle", 4'h4, 32'h0);

        rx_inject(8'h55);
        rd_chk("t4_status", 4'h4, 32'h1);
        rd_chk("t4_data", 4'h0, 32'h55);
        rd_chk("t4_empty", 4'h0, 32'h100);

        for (int i = 0; i < 17; i++) rx_inject(8'h10 + i);
        rd_chk("t5_ovr_status", 4'h4, 32'h5);
        for (int i = 0; i < 16; i++) rd_chk("t5_data", 4'h0, 32'h10 + i);
        rd_chk("t5_lost", 4'h0, 32'h100);
        rd_chk("t5_sticky", 4'h4, 32'h4);
        wr("t5_clr", 4'h4, 32'h4, 4'h1);
        rd_chk("t5_cleared", 4'h4, 32'h0);

        for (int i = 0; i < 16; i++) rx_inject(8'h20 + i);
        fork
            bus(BASE, 32'h0, 4'h0, rd, lat);
            rx_inject(8'h30);
        join
        check("t5_pp_data", rd, 32'h20);
        rd_chk("t5_pp_status", 4'h4, 32'h1);
        for (int i = 0; i < 16; i++) rd_chk("t5_pp_drain", 4'h0, 32'h21 + i);
        rd_chk("t5_pp_empty", 4'h0, 32'h100);

        fork
            bus(BASE, 32'h0, 4'h0, rd, lat);
            rx_inject(8'h77);
        join
        check("emp_push_rd", rd, 32'h100);
        rd_chk("emp_push_data", 4'h0, 32'h77);

        rd_chk("off3", 4'hC, 32'h0);
        bus(32'h0300_0000, 32'h0, 4'h0, rd, lat);
        check("miss_noack", lat, -1);

`ifdef UART_MMIO_IRQ_EN
        check("irq_rst", irq, 0);
        wr("t6_en", 4'h8, 32'h1, 4'h1);
        rd_chk("t6_en_rd", 4'h8, 32'h1);
        rx_inject(8'hAB);
        @(negedge clk);
        check("t6_irq_on", irq, 1);
        rd_chk("t6_data", 4'h0, 32'hAB);
        @(negedge clk);
        check("t6_irq_off", irq, 0);
`else
        wr("irqen_w", 4'h8, 32'h3, 4'h1);
        rd_chk("irqen_rd", 4'h8, 32'h0);
`endif

        check("tx_data_stable", unstable, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
